// File: rtl/countdown_ctrl_if.sv
// Countdown overlay control bundle: frame timing and requests in, digit and status out.
interface countdown_ctrl_if;
  logic       vsync_in;
  logic       start;
  logic       abort;
  logic [1:0] digit;
  logic       digit_en;
  logic       busy;
  logic       countdown_done;

  modport master (
    output vsync_in, start, abort,
    input  digit, digit_en, busy, countdown_done
  );

  modport slave (
    input  vsync_in, start, abort,
    output digit, digit_en, busy, countdown_done
  );
endinterface

// File: rtl/countdown_ctrl.sv
// 3-2-1 on-screen countdown sequencer; each digit is held for FRAMES_PER_DIGIT video frames.
module countdown_ctrl #(
  parameter int FRAMES_PER_DIGIT = 60,
  parameter int FCNT_W           = 8
) (
  input  logic            pclk,
  input  logic            reset,
  countdown_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    CNT3 = 3'd2,
    CNT2 = 3'd3,
    CNT1 = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [FCNT_W-1:0] LAST_FRAME = FCNT_W'(FRAMES_PER_DIGIT - 1);

  state_t              state, state_nx;
  logic [FCNT_W-1:0]   frame_cnt, frame_cnt_nx;
  logic                vsync_d;
  logic                frame_tick;

  // vsync_d resets high so a vsync already asserted at reset release is not a new frame
  assign frame_tick = bus.vsync_in & ~vsync_d;

  always_ff @(posedge pclk) begin
    if (reset) begin
      state     <= IDLE;
      frame_cnt <= '0;
      vsync_d   <= 1'b1;
    end else begin
      state     <= state_nx;
      frame_cnt <= frame_cnt_nx;
      vsync_d   <= bus.vsync_in;
    end
  end

  always_comb begin
    state_nx           = state;
    frame_cnt_nx       = frame_cnt;
    bus.digit          = 2'd0;
    bus.digit_en       = 1'b0;
    bus.busy           = 1'b1;
    bus.countdown_done = 1'b0;

    if (bus.abort) begin
      state_nx     = IDLE;
      frame_cnt_nx = '0;
    end else begin
      case (state)
        IDLE: if (bus.start) state_nx = ARM;
        ARM: begin
          if (frame_tick) begin
            state_nx     = CNT3;
            frame_cnt_nx = '0;
          end
        end
        CNT3, CNT2, CNT1: begin
          if (frame_tick) begin
            if (frame_cnt == LAST_FRAME) begin
              frame_cnt_nx = '0;
              case (state)
                CNT3:    state_nx = CNT2;
                CNT2:    state_nx = CNT1;
                default: state_nx = DONE;
              endcase
            end else begin
              frame_cnt_nx = frame_cnt + FCNT_W'(1);
            end
          end
        end
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end

    // Moore decode: outputs depend on the state register only
    case (state)
      IDLE: bus.busy = 1'b0;
      CNT3: begin
        bus.digit    = 2'd3;
        bus.digit_en = 1'b1;
      end
      CNT2: begin
        bus.digit    = 2'd2;
        bus.digit_en = 1'b1;
      end
      CNT1: begin
        bus.digit    = 2'd1;
        bus.digit_en = 1'b1;
      end
      DONE:    bus.countdown_done = 1'b1;
      ARM:     bus.busy = 1'b1;
      default: bus.busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench: one instance with 2 frames per digit, one with 1 frame per digit.
module tb_countdown_ctrl;

  // Packed view {digit[1:0], digit_en, busy, countdown_done}
  localparam logic [4:0] S_IDLE = 5'b00_0_0_0;
  localparam logic [4:0] S_ARM  = 5'b00_0_1_0;
  localparam logic [4:0] S_CNT3 = 5'b11_1_1_0;
  localparam logic [4:0] S_CNT2 = 5'b10_1_1_0;
  localparam logic [4:0] S_CNT1 = 5'b01_1_1_0;
  localparam logic [4:0] S_DONE = 5'b00_0_1_1;

  logic pclk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   done_a = 0;
  int   done_b = 0;

  countdown_ctrl_if ifa ();
  countdown_ctrl_if ifb ();

  assign ifb.vsync_in = ifa.vsync_in;

  countdown_ctrl #(.FRAMES_PER_DIGIT(2), .FCNT_W(8)) dut_a (
    .pclk  (pclk),
    .reset (reset),
    .bus   (ifa)
  );

  countdown_ctrl #(.FRAMES_PER_DIGIT(1), .FCNT_W(8)) dut_b (
    .pclk  (pclk),
    .reset (reset),
    .bus   (ifb)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (ifa.countdown_done === 1'b1) done_a++;
    if (ifb.countdown_done === 1'b1) done_b++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [4:0] exp);
    chk(tag, {3'b000, ifa.digit, ifa.digit_en, ifa.busy, ifa.countdown_done}, {3'b000, exp});
  endtask

  task automatic chk_b(input string tag, input logic [4:0] exp);
    chk(tag, {3'b000, ifb.digit, ifb.digit_en, ifb.busy, ifb.countdown_done}, {3'b000, exp});
  endtask

  task automatic vs_rise();
    ifa.vsync_in = 1'b1;
    cyc(1);
  endtask

  task automatic vs_rest();
    cyc(9);
    ifa.vsync_in = 1'b0;
    cyc(90);
  endtask

  task automatic tick_a(input string tag, input logic [4:0] exp);
    vs_rise();
    chk_a(tag, exp);
    vs_rest();
  endtask

  task automatic tick_b(input string tag, input logic [4:0] exp);
    vs_rise();
    chk_b(tag, exp);
    vs_rest();
  endtask

  initial begin
    reset        = 1'b1;
    ifa.vsync_in = 1'b1;
    ifa.start    = 1'b0;
    ifa.abort    = 1'b0;
    ifb.start    = 1'b0;
    ifb.abort    = 1'b0;
    cyc(3);

    // Reset state, vsync held high across reset release
    chk_a("reset_a", S_IDLE);
    chk_b("reset_b", S_IDLE);
    chk("tick_in_reset", {7'd0, dut_a.frame_tick}, 8'd0);
    reset = 1'b0;
    #1;
    chk("tick_at_release", {7'd0, dut_a.frame_tick}, 8'd0);
    cyc(2);
    chk_a("idle_after_release", S_IDLE);
    ifa.vsync_in = 1'b0;
    cyc(50);

    // Nominal run, with start re-asserted during CNT3
    ifa.start = 1'b1;
    cyc(1);
    ifa.start = 1'b0;
    chk_a("nom_arm", S_ARM);
    cyc(20);
    chk_a("nom_arm_hold", S_ARM);
    vs_rise();
    chk_a("nom_t1_cnt3", S_CNT3);
    ifa.start = 1'b1;
    cyc(3);
    ifa.start = 1'b0;
    chk_a("nom_cnt3_start_ignored", S_CNT3);
    vs_rest();
    tick_a("nom_t2_cnt3", S_CNT3);
    tick_a("nom_t3_cnt2", S_CNT2);
    tick_a("nom_t4_cnt2", S_CNT2);
    tick_a("nom_t5_cnt1", S_CNT1);
    tick_a("nom_t6_cnt1", S_CNT1);
    vs_rise();
    chk_a("nom_t7_done", S_DONE);
    cyc(1);
    chk_a("nom_idle", S_IDLE);
    chk("nom_done_count", done_a[7:0], 8'd1);
    vs_rest();

    // start and abort together in IDLE
    ifa.start = 1'b1;
    ifa.abort = 1'b1;
    cyc(2);
    chk_a("sim_idle", S_IDLE);
    ifa.start = 1'b0;
    ifa.abort = 1'b0;

    // Abort while digit 2 is shown
    ifa.start = 1'b1;
    cyc(1);
    ifa.start = 1'b0;
    tick_a("ab_t1_cnt3", S_CNT3);
    tick_a("ab_t2_cnt3", S_CNT3);
    vs_rise();
    chk_a("ab_t3_cnt2", S_CNT2);
    ifa.abort = 1'b1;
    cyc(1);
    ifa.abort = 1'b0;
    chk_a("ab_idle", S_IDLE);
    vs_rest();
    tick_a("ab_stays_idle", S_IDLE);
    chk("ab_done_count", done_a[7:0], 8'd1);

    // Reset during CNT1
    ifa.start = 1'b1;
    cyc(1);
    ifa.start = 1'b0;
    tick_a("rs_t1_cnt3", S_CNT3);
    tick_a("rs_t2_cnt3", S_CNT3);
    tick_a("rs_t3_cnt2", S_CNT2);
    tick_a("rs_t4_cnt2", S_CNT2);
    vs_rise();
    chk_a("rs_t5_cnt1", S_CNT1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk_a("rs_idle", S_IDLE);
    vs_rest();
    tick_a("rs_stays_idle", S_IDLE);
    tick_a("rs_stays_idle2", S_IDLE);
    chk("rs_done_count", done_a[7:0], 8'd1);

    // One frame per digit; tick coincident with start must not count
    ifb.start = 1'b1;
    vs_rise();
    ifb.start = 1'b0;
    chk_b("b_arm_tick_ignored", S_ARM);
    vs_rest();
    chk_b("b_arm_hold", S_ARM);
    tick_b("b_t1_cnt3", S_CNT3);
    tick_b("b_t2_cnt2", S_CNT2);
    tick_b("b_t3_cnt1", S_CNT1);
    vs_rise();
    chk_b("b_t4_done", S_DONE);
    cyc(1);
    chk_b("b_idle", S_IDLE);
    chk("b_done_count", done_b[7:0], 8'd1);
    chk_a("a_idle_end", S_IDLE);
    vs_rest();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/countdown_ctrl.md
COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

Interface
REQ-001 The block SHALL use clock pclk and reset reset, synchronous, active-high.
REQ-002 Parameter FRAMES_PER_DIGIT, default 60, SHALL set the number of video frames each digit is shown; legal range 1..255.
REQ-003 Parameter FCNT_W, default 8, SHALL set the frame counter width; FCNT_W bits SHALL hold FRAMES_PER_DIGIT-1.
REQ-004 pclk  in  1  pixel clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 vsync_in  in  1  vertical sync from the timing chain; the rising edge marks the frame boundary.
REQ-007 start  in  1  request to begin the countdown; sampled only in IDLE.
REQ-008 abort  in  1  cancels the countdown from any state.
REQ-009 digit  out  2  digit the draw block renders: 3, 2 or 1, with 0 meaning none.
REQ-010 digit_en  out  1  high while digit is valid and must be drawn.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 countdown_done  out  1  one-cycle pulse when the countdown completes normally.

Function
REQ-013 Frame tick: register vsync_d <= vsync_in; frame_tick = vsync_in & ~vsync_d; frame_tick SHALL last exactly one pclk cycle per vsync rising edge.
REQ-014 The FSM SHALL have the states IDLE, ARM, CNT3, CNT2, CNT1 and DONE, held in a single state register.
REQ-015 IDLE: start=1 and abort=0 -> ARM on the next edge.
REQ-016 ARM: frame_tick -> CNT3 with frame_cnt <= 0, so a digit always appears on a frame boundary.
REQ-017 CNTn (n=3,2,1) on frame_tick: if frame_cnt == FRAMES_PER_DIGIT-1, advance (CNT3->CNT2->CNT1->DONE) and set frame_cnt <= 0; otherwise frame_cnt <= frame_cnt+1.
REQ-018 CNTn with no frame_tick: state and frame_cnt SHALL hold.
REQ-019 Each digit SHALL therefore stay visible for exactly FRAMES_PER_DIGIT frames.
REQ-020 DONE SHALL last exactly one cycle, then move unconditionally to IDLE.
REQ-021 abort=1 SHALL force IDLE on the next edge from any state, including DONE; abort has priority over start and frame_tick; countdown_done SHALL NOT pulse on abort.
REQ-022 start outside IDLE SHALL be ignored; start held high SHALL retrigger only after the block returns to IDLE.
REQ-023 Outputs SHALL be Moore outputs, registered from the state register value, i.e. valid in the cycle the state is entered, with no combinational path from any input.
REQ-024 Output decode: CNT3 -> digit=3, digit_en=1; CNT2 -> digit=2, digit_en=1; CNT1 -> digit=1, digit_en=1; every other state -> digit=0, digit_en=0.
REQ-025 busy SHALL be 1 in ARM, CNT3, CNT2, CNT1 and DONE.
REQ-026 countdown_done SHALL be 1 only in DONE.
REQ-027 With FRAMES_PER_DIGIT=1, every frame_tick in CNTn SHALL advance the state.
REQ-028 A frame_tick in the same cycle as the start sample in IDLE SHALL NOT count; ARM waits for the next tick.

Reset
REQ-029 On reset the block SHALL set state=IDLE, frame_cnt=0, digit=0, digit_en=0, busy=0, countdown_done=0 and vsync_d=1.
REQ-030 With vsync_d reset to 1, vsync_in already high when reset is released SHALL NOT produce a frame_tick.
REQ-031 Reset asserted mid-countdown SHALL abandon the sequence with no countdown_done pulse.

Verification (FRAMES_PER_DIGIT=2, vsync period 100 cycles)
REQ-032 Nominal: start pulse in IDLE -> busy=1 next cycle; digit=3 on the cycle after the first tick; digit=2 two ticks later; digit=1 two ticks after that; countdown_done pulses for 1 cycle two ticks after that; then IDLE with busy=0.
REQ-033 Abort: abort=1 while digit=2 -> digit=0, digit_en=0, busy=0 next cycle; countdown_done stays 0 throughout.
REQ-034 Simultaneous: start=1 and abort=1 in IDLE -> remains IDLE, busy=0; start while in CNT3 -> sequence timing unchanged.
REQ-035 Boundary: FRAMES_PER_DIGIT=1 -> digits 3/2/1 each last exactly 1 frame; done pulse on the cycle after the 4th tick after ARM.
REQ-036 Reset: vsync_in held high through reset release -> no spurious tick; reset asserted during CNT1 -> all outputs 0 next cycle, no done pulse.
